// File: rtl/cam_pkg.sv
// Shared camera-side constants and the frame-capture state type.
package cam_pkg;

    localparam int unsigned IMG_W       = 320;
    localparam int unsigned IMG_H       = 240;
    localparam int unsigned IMG_NPIX    = IMG_W * IMG_H;
    localparam int unsigned IMG_ADDR_W  = 17;
    localparam int unsigned PIX_COORD_W = 10;

    typedef enum logic [1:0] {
        CapIdle,
        CapWaitSof,
        CapCapture,
        CapDone
    } cap_state_e;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one synchronous write port, one registered read port
// returning old data on a same-address collision.
module frame_ram
    import cam_pkg::*;
#(
    parameter int unsigned NPIX   = IMG_NPIX,
    parameter int unsigned ADDR_W = IMG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [NPIX];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reset touches only the output register, so the array still maps onto block RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/frame_capture.sv
// Arms on cap_req, waits for start-of-frame and stores one raster-ordered frame into frame_ram;
// raster breaks flag seq_err and re-arm the capture.
module frame_capture
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH  = IMG_W,
    parameter int unsigned HEIGHT = IMG_H,
    parameter int unsigned ADDR_W = IMG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             pix_value,
    input  logic [PIX_COORD_W-1:0] pix_x,
    input  logic [PIX_COORD_W-1:0] pix_y,
    input  logic                   pix_val,
    input  logic                   cap_req,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_ready,
    output logic                   seq_err,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [7:0]             rd_data
);

    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    // One spare bit so the counter can hold NPIX itself ("whole frame written").
    localparam int unsigned CNT_W = ADDR_W + 1;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] exp_addr_q, exp_addr_d;
    logic             frame_ready_q, frame_ready_d;
    logic             seq_err_q, seq_err_d;

    logic        wr_en;
    logic [31:0] pix_addr;
    logic        pix_in_range;
    logic        pix_in_order;
    logic        is_sof;
    logic        frame_complete;

    // Full-width address so out-of-range coordinates can never alias onto a valid slot.
    assign pix_addr       = 32'(pix_y) * WIDTH + 32'(pix_x);
    assign pix_in_range   = (32'(pix_x) < WIDTH) && (32'(pix_y) < HEIGHT);
    assign pix_in_order   = (pix_addr == 32'(exp_addr_q));
    assign is_sof         = (pix_x == '0) && (pix_y == '0);
    assign frame_complete = (exp_addr_q == CNT_W'(NPIX));

    always_comb begin
        state_d       = state_q;
        exp_addr_d    = exp_addr_q;
        frame_ready_d = frame_ready_q;
        seq_err_d     = seq_err_q;
        wr_en         = 1'b0;
        case (state_q)
            CapIdle: begin
                if (cap_req) begin
                    state_d       = CapWaitSof;
                    frame_ready_d = 1'b0;
                    seq_err_d     = 1'b0;
                end
            end
            CapWaitSof: begin
                if (pix_val && is_sof) begin
                    wr_en      = 1'b1;
                    exp_addr_d = CNT_W'(1);
                    state_d    = CapCapture;
                end
            end
            CapCapture: begin
                // The last pixel's write lands first; completion is reported one edge later.
                if (frame_complete) begin
                    state_d       = CapDone;
                    frame_ready_d = 1'b1;
                end else if (pix_val) begin
                    if (pix_in_range && pix_in_order) begin
                        wr_en      = 1'b1;
                        exp_addr_d = exp_addr_q + CNT_W'(1);
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = CapWaitSof;
                    end
                end
            end
            CapDone: begin
                state_d = CapIdle;
            end
            default: begin
                state_d = CapIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CapIdle;
            exp_addr_q    <= '0;
            frame_ready_q <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_addr_q    <= exp_addr_d;
            frame_ready_q <= frame_ready_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign busy        = (state_q == CapWaitSof) || (state_q == CapCapture);
    assign frame_done  = (state_q == CapDone);
    assign frame_ready = frame_ready_q;
    assign seq_err     = seq_err_q;

    frame_ram #(
        .NPIX  (NPIX),
        .ADDR_W(ADDR_W)
    ) u_frame_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(pix_addr[ADDR_W-1:0]),
        .wr_data(pix_value),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture on a reduced 24x10 raster to keep run time short.
module tb_frame_capture;

    localparam int W    = 24;
    localparam int H    = 10;
    localparam int NPIX = W * H;
    localparam int AW   = 8;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CAPT  = 2;
    localparam int M_FIN   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    pix_value = '0;
    logic [9:0]    pix_x = '0;
    logic [9:0]    pix_y = '0;
    logic          pix_val = 1'b0;
    logic          cap_req = 1'b0;
    logic          busy, frame_done, frame_ready, seq_err;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;

    frame_capture #(
        .WIDTH (W),
        .HEIGHT(H),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_value  (pix_value),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_val    (pix_val),
        .cap_req    (cap_req),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_ready(frame_ready),
        .seq_err    (seq_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int done_seen = 0;
    int cyc_done = -1;
    int last_cyc = -1;
    int bad_cyc = -1;
    int err_rise = -1;
    bit err_prev = 1'b0;
    bit rd_hold = 1'b0;

    // Reference: a frame is a raster of NPIX pixels accepted strictly in order after arming.
    int m_mode = M_IDLE;
    int m_next = 0;
    bit m_ready = 1'b0;
    bit m_err = 1'b0;
    int m_mem [NPIX];
    bit m_known [NPIX];
    int m_rd_exp = 0;
    bit m_rd_known = 1'b0;

    function automatic int pv(input int x, input int y, input int s);
        return (x * 7 + y * 13 + s * 31) & 255;
    endfunction

    function automatic void model_step(input bit rst, input bit rq, input bit v, input int x,
                                       input int y, input int val, input int ra);
        int idx;
        if (rst) begin
            m_mode = M_IDLE;
            m_next = 0;
            m_ready = 1'b0;
            m_err = 1'b0;
            m_rd_exp = 0;
            m_rd_known = 1'b1;
            for (int i = 0; i < NPIX; i++) m_known[i] = 1'b0;
            return;
        end
        m_rd_known = m_known[ra];
        m_rd_exp = m_mem[ra];
        if (m_mode == M_IDLE) begin
            if (rq) begin
                m_mode = M_ARMED;
                m_ready = 1'b0;
                m_err = 1'b0;
            end
        end else if (m_mode == M_ARMED) begin
            if (v && x == 0 && y == 0) begin
                m_mem[0] = val;
                m_known[0] = 1'b1;
                m_next = 1;
                m_mode = M_CAPT;
            end
        end else if (m_mode == M_CAPT) begin
            if (m_next == NPIX) begin
                m_mode = M_FIN;
                m_ready = 1'b1;
            end else if (v) begin
                idx = y * W + x;
                if (x >= W || y >= H || idx != m_next) begin
                    m_err = 1'b1;
                    m_mode = M_ARMED;
                end else begin
                    m_mem[idx] = val;
                    m_known[idx] = 1'b1;
                    m_next = idx + 1;
                end
            end
        end else begin
            m_mode = M_IDLE;
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic cyc(input bit rq, input bit v, input int x, input int y, input int val,
                       input bit rst);
        if (!rd_hold) rd_addr = AW'($urandom_range(NPIX - 1, 0));
        reset = rst;
        cap_req = rq;
        pix_val = v;
        pix_x = 10'(x);
        pix_y = 10'(y);
        pix_value = 8'(val);
        @(posedge clk);
        model_step(rst, rq, v, x, y, val, int'(rd_addr));
        cyc_n++;
        #1;
        chk("busy", int'(busy), int'(m_mode == M_ARMED || m_mode == M_CAPT));
        chk("frame_done", int'(frame_done), int'(m_mode == M_FIN));
        chk("frame_ready", int'(frame_ready), int'(m_ready));
        chk("seq_err", int'(seq_err), int'(m_err));
        if (m_rd_known) chk("rd_data", int'(rd_data), m_rd_exp);
        if (frame_done) begin
            done_seen++;
            cyc_done = cyc_n;
        end
        if (seq_err && !err_prev) err_rise = cyc_n;
        err_prev = seq_err;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Streams raster indices [first, last) at one pixel per `rate` cycles.
    task automatic stream(input int seed, input int rate, input int first, input int last,
                          input int rq_idx, input int skip_idx);
        int x, y;
        for (int i = first; i < last; i++) begin
            if (i == skip_idx) continue;
            x = i % W;
            y = i / W;
            cyc(i == rq_idx, 1'b1, x, y, pv(x, y, seed), 1'b0);
            if (skip_idx >= 0 && i == skip_idx + 1) bad_cyc = cyc_n;
            if (i == NPIX - 1) last_cyc = cyc_n;
            for (int k = 1; k < rate; k++)
                cyc(1'b0, 1'b0, int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                    int'($urandom_range(255, 0)), 1'b0);
        end
    endtask

    task automatic rb(input int addr, input int exp, input string nm);
        rd_hold = 1'b1;
        rd_addr = AW'(addr);
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
        chk(nm, int'(rd_data), exp);
        rd_hold = 1'b0;
    endtask

    typedef struct {
        bit rst, rq, v;
        int x, y;
        bit busy, done, ready, err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};  // reset
        tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};  // SOF while not armed
        tbl[2]  = '{0, 1, 1, 0, 0, 1, 0, 0, 0};  // arm; same-cycle SOF ignored
        tbl[3]  = '{0, 0, 1, 3, 0, 1, 0, 0, 0};  // discarded
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};  // SOF coords without pix_val
        tbl[5]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};  // SOF accepted
        tbl[6]  = '{0, 0, 1, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0};  // cap_req while capturing
        tbl[8]  = '{0, 0, 1, 2, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 4, 0, 1, 0, 0, 1};  // skipped x=3
        tbl[10] = '{0, 0, 1, 5, 0, 1, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 1, 0, 0, 1};  // cap_req while waiting
        tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rq, tbl[i].v, tbl[i].x, tbl[i].y, pv(tbl[i].x, tbl[i].y, 3), tbl[i].rst);
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), int'(frame_done), int'(tbl[i].done));
            chk($sformatf("tbl%0d_ready", i), int'(frame_ready), int'(tbl[i].ready));
            chk($sformatf("tbl%0d_err", i), int'(seq_err), int'(tbl[i].err));
        end

        // Unarmed: a full frame streams past without any capture.
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
        done_seen = 0;
        stream(1, 1, 0, NPIX, -1, -1);
        idle(3);
        chk("unarmed_done_count", done_seen, 0);
        chk("unarmed_ready", int'(frame_ready), 0);

        // Arm mid-frame, then one alternate-rate frame.
        stream(5, 2, 0, NPIX, 2 * W + 5, -1);
        chk("midframe_no_done", done_seen, 0);
        stream(6, 2, 0, NPIX, -1, -1);
        idle(3);
        chk("alt_done_count", done_seen, 1);
        chk("alt_done_delay", cyc_done - last_cyc, 1);
        chk("alt_ready", int'(frame_ready), 1);
        rb(0, pv(0, 0, 6), "rb_first");
        rb(W + 1, pv(1, 1, 6), "rb_diag");
        rb(NPIX - 1, pv(W - 1, H - 1, 6), "rb_last");

        // Re-arm from frame_ready, then back-to-back frame and full read-back.
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("rearm_ready_clr", int'(frame_ready), 0);
        chk("rearm_busy", int'(busy), 1);
        begin
            int sof_cyc;
            sof_cyc = cyc_n + 1;
            stream(7, 1, 0, NPIX, -1, -1);
            idle(2);
            chk("b2b_latency", cyc_done - sof_cyc, NPIX);
        end
        for (int i = 0; i < NPIX; i++) rb(i, pv(i % W, i / W, 7), "rb_full");

        // Skipped pixel on row 5, then a clean frame with a stray cap_req.
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        err_rise = -1;
        stream(8, 1, 0, NPIX, -1, 5 * W + 11);
        chk("skip_err_edge", err_rise, bad_cyc);
        done_seen = 0;
        stream(9, 2, 0, NPIX, 3 * W, -1);
        idle(2);
        chk("clean_done_count", done_seen, 1);
        chk("clean_ready", int'(frame_ready), 1);
        chk("clean_err_sticky", int'(seq_err), 1);
        rb(W + 1, pv(1, 1, 9), "rb_clean");
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("err_cleared", int'(seq_err), 0);

        // Reset in the middle of a capture, then a normal capture.
        stream(10, 1, 0, 5 * W + 20, -1, -1);
        cyc(1'b0, 1'b1, 20, 5, pv(20, 5, 10), 1'b1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_ready", int'(frame_ready), 0);
        chk("rst_err", int'(seq_err), 0);
        chk("rst_rd", int'(rd_data), 0);
        done_seen = 0;
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
        stream(11, 1, 0, NPIX, -1, -1);
        idle(2);
        chk("post_rst_done", done_seen, 1);
        rb(0, pv(0, 0, 11), "rb_post_rst0");
        rb(NPIX - 1, pv(W - 1, H - 1, 11), "rb_post_rst_last");

        // Randomised traffic checked against the reference.
        begin
            int g, x, y;
            bit v, rq, rst;
            g = 0;
            cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
            for (int n = 0; n < 3000; n++) begin
                rq = ($urandom_range(79, 0) == 0);
                rst = ($urandom_range(1499, 0) == 0);
                v = ($urandom_range(3, 0) != 0);
                if (v) begin
                    if ($urandom_range(199, 0) == 0) g = (g + 1) % NPIX;
                    x = g % W;
                    y = g / W;
                    if ($urandom_range(299, 0) == 0) x = W + int'($urandom_range(4, 0));
                    g = (g + 1) % NPIX;
                end else begin
                    x = int'($urandom_range(1023, 0));
                    y = int'($urandom_range(1023, 0));
                end
                cyc(rq, v, x, y, int'($urandom_range(255, 0)), rst);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
